wg_host_arbiter: RTL and testbench

WG_HOST_ARBITER -- requirements
Module: wg_host_arbiter

---
 rtl/wg_host_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_wg_host_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wg_host_arbiter.sv
// -----------------------------------------------------------------------------
// wg_host_arbiter
// Two-requester round-robin arbiter that offers one workgroup at a time to the
// inflight WG buffer and tracks how many issued workgroups are still running.
//
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   req_valid[1:0]                    per-requester workgroup pending
//   req_wg_id / req_num_wf / req_desc per-requester payload, requester i in slice i
//   req_ack[1:0]                      one-cycle one-hot pulse: payload i captured
//   host_wg_valid                     workgroup offered to the inflight buffer
//   host_wg_id / host_num_wf / host_desc  offered payload
//   inflight_wg_buffer_host_rcvd_ack  buffer accepted the offered workgroup
//   wg_done                           one-cycle pulse: an issued workgroup completed
//   inflight_count                    issued-but-not-completed workgroups
//   underflow_err                     sticky: wg_done seen with nothing in flight
//
// Optional feature (macro WG_HOST_ARBITER_STATS_EN):
//   grant_cnt0 / grant_cnt1           16-bit wrapping grant counters per requester
// -----------------------------------------------------------------------------
module wg_host_arbiter #(
    parameter int unsigned WG_ID_WIDTH    = 6,
    parameter int unsigned WF_COUNT_WIDTH = 4,
    parameter int unsigned DESC_WIDTH     = 64,
    parameter int unsigned MAX_INFLIGHT   = 8,
    localparam int unsigned CNT_W         = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  req_valid,
    input  logic [2*WG_ID_WIDTH-1:0]    req_wg_id,
    input  logic [2*WF_COUNT_WIDTH-1:0] req_num_wf,
    input  logic [2*DESC_WIDTH-1:0]     req_desc,
    output logic [1:0]                  req_ack,
    output logic                        host_wg_valid,
    output logic [WG_ID_WIDTH-1:0]      host_wg_id,
    output logic [WF_COUNT_WIDTH-1:0]   host_num_wf,
    output logic [DESC_WIDTH-1:0]       host_desc,
    input  logic                        inflight_wg_buffer_host_rcvd_ack,
    input  logic                        wg_done,
    output logic [CNT_W-1:0]            inflight_count,
    output logic                        underflow_err
`ifdef WG_HOST_ARBITER_STATS_EN
    ,
    output logic [15:0]                 grant_cnt0,
    output logic [15:0]                 grant_cnt1
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WG_ID_WIDTH-1:0]    wg_id;
        logic [WF_COUNT_WIDTH-1:0] num_wf;
        logic [DESC_WIDTH-1:0]     desc;
    } payload_t;

    state_t            state_q, state_d;
    payload_t          pl_q, pl_d, sel_pl;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        req_ack_d;
    logic              host_wg_valid_d;
    logic [CNT_W-1:0]  count_d;
    logic              underflow_d;
    logic              can_grant;
    logic              winner;
    logic              accept;
    logic              inc;

    // Eligibility and round-robin winner (tie goes to the one not granted last)
    assign can_grant = (|req_valid) && (inflight_count < CNT_MAX);
    assign winner    = (&req_valid) ? ~last_grant_q : req_valid[1];

    // Acceptance only counts while an offer is actually outstanding
    assign accept    = host_wg_valid && inflight_wg_buffer_host_rcvd_ack;
    assign inc       = (state_q == ISSUE) && accept;

    // Winner's payload slice
    always_comb begin
        if (winner) begin
            sel_pl = {req_wg_id[2*WG_ID_WIDTH-1:WG_ID_WIDTH],
                      req_num_wf[2*WF_COUNT_WIDTH-1:WF_COUNT_WIDTH],
                      req_desc[2*DESC_WIDTH-1:DESC_WIDTH]};
        end else begin
            sel_pl = {req_wg_id[WG_ID_WIDTH-1:0],
                      req_num_wf[WF_COUNT_WIDTH-1:0],
                      req_desc[DESC_WIDTH-1:0]};
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pl_q           <= '0;
            last_grant_q   <= 1'b1;
            req_ack        <= 2'b00;
            host_wg_valid  <= 1'b0;
            inflight_count <= '0;
            underflow_err  <= 1'b0;
        end else begin
            state_q        <= state_d;
            pl_q           <= pl_d;
            last_grant_q   <= last_grant_d;
            req_ack        <= req_ack_d;
            host_wg_valid  <= host_wg_valid_d;
            inflight_count <= count_d;
            underflow_err  <= underflow_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (can_grant) state_d = ISSUE;
            ISSUE:   if (accept)    state_d = GAP;
            GAP:                    state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        req_ack_d       = 2'b00;
        host_wg_valid_d = host_wg_valid;
        pl_d            = pl_q;
        last_grant_d    = last_grant_q;
        case (state_q)
            IDLE: begin
                if (can_grant) begin
                    req_ack_d       = winner ? 2'b10 : 2'b01;
                    host_wg_valid_d = 1'b1;
                    pl_d            = sel_pl;
                    last_grant_d    = winner;
                end
            end
            ISSUE: begin
                if (accept) host_wg_valid_d = 1'b0;
            end
            GAP: begin
                host_wg_valid_d = 1'b0;
            end
            default: begin
                host_wg_valid_d = 1'b0;
            end
        endcase
    end

    // In-flight counter: simultaneous issue and completion cancel out
    always_comb begin
        count_d     = inflight_count;
        underflow_d = underflow_err;
        if (inc && !wg_done) begin
            count_d = inflight_count + CNT_W'(1);
        end else if (!inc && wg_done) begin
            if (inflight_count == '0) begin
                underflow_d = 1'b1;
            end else begin
                count_d = inflight_count - CNT_W'(1);
            end
        end
    end

    assign host_wg_id  = pl_q.wg_id;
    assign host_num_wf = pl_q.num_wf;
    assign host_desc   = pl_q.desc;

`ifdef WG_HOST_ARBITER_STATS_EN
    // Per-requester grant counters, bumped on the same edge as req_ack rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= 16'h0000;
            grant_cnt1 <= 16'h0000;
        end else begin
            grant_cnt0 <= grant_cnt0 + 16'(req_ack_d[0]);
            grant_cnt1 <= grant_cnt1 + 16'(req_ack_d[1]);
        end
    end
`endif

endmodule

// File: tb/tb_wg_host_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wg_host_arbiter
// Self-checking bench for wg_host_arbiter (MAX_INFLIGHT = 2): a directed
// vector table, a hand-written asynchronous-reset sequence, and a randomized
// run compared against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_wg_host_arbiter;

    localparam int unsigned WG_W   = 6;
    localparam int unsigned WF_W   = 4;
    localparam int unsigned DESC_W = 64;
    localparam int unsigned MAX    = 2;
    localparam int unsigned CNT_W  = $clog2(MAX + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           req_valid = 2'b00;
    logic [2*WG_W-1:0]    req_wg_id = '0;
    logic [2*WF_W-1:0]    req_num_wf = '0;
    logic [2*DESC_W-1:0]  req_desc = '0;
    logic [1:0]           req_ack;
    logic                 host_wg_valid;
    logic [WG_W-1:0]      host_wg_id;
    logic [WF_W-1:0]      host_num_wf;
    logic [DESC_W-1:0]    host_desc;
    logic                 rcvd = 1'b0;
    logic                 wg_done = 1'b0;
    logic [CNT_W-1:0]     inflight_count;
    logic                 underflow_err;
`ifdef WG_HOST_ARBITER_STATS_EN
    logic [15:0]          grant_cnt0;
    logic [15:0]          grant_cnt1;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit use_model = 1'b0;

    wg_host_arbiter #(
        .WG_ID_WIDTH   (WG_W),
        .WF_COUNT_WIDTH(WF_W),
        .DESC_WIDTH    (DESC_W),
        .MAX_INFLIGHT  (MAX)
    ) dut (
        .clk                             (clk),
        .rst                             (rst),
        .req_valid                       (req_valid),
        .req_wg_id                       (req_wg_id),
        .req_num_wf                      (req_num_wf),
        .req_desc                        (req_desc),
        .req_ack                         (req_ack),
        .host_wg_valid                   (host_wg_valid),
        .host_wg_id                      (host_wg_id),
        .host_num_wf                     (host_num_wf),
        .host_desc                       (host_desc),
        .inflight_wg_buffer_host_rcvd_ack(rcvd),
        .wg_done                         (wg_done),
        .inflight_count                  (inflight_count),
        .underflow_err                   (underflow_err)
`ifdef WG_HOST_ARBITER_STATS_EN
        ,
        .grant_cnt0                      (grant_cnt0),
        .grant_cnt1                      (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    bit          m_offer;
    bit          m_gap;
    logic [1:0]  m_ack;
    logic [WG_W-1:0]   m_id;
    logic [WF_W-1:0]   m_nwf;
    logic [DESC_W-1:0] m_desc;
    int          m_cnt;
    bit          m_uf;
    int          m_last;
    int          m_g0;
    int          m_g1;

    task automatic model_reset();
        m_offer = 1'b0; m_gap = 1'b0; m_ack = 2'b00;
        m_id = '0; m_nwf = '0; m_desc = '0;
        m_cnt = 0; m_uf = 1'b0; m_last = 1; m_g0 = 0; m_g1 = 0;
    endtask

    // One rising edge worth of behaviour, using the inputs present at the edge
    task automatic model_step();
        int w;
        int inc;
        if (rst) begin
            model_reset();
            return;
        end
        inc   = 0;
        m_ack = 2'b00;
        if (m_offer) begin
            if (rcvd) begin
                m_offer = 1'b0;
                m_gap   = 1'b1;
                inc     = 1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (req_valid != 2'b00 && m_cnt < int'(MAX)) begin
            if (req_valid == 2'b11) w = 1 - m_last;
            else                    w = req_valid[1] ? 1 : 0;
            m_last  = w;
            m_offer = 1'b1;
            if (w == 1) begin
                m_ack  = 2'b10;
                m_id   = req_wg_id[2*WG_W-1:WG_W];
                m_nwf  = req_num_wf[2*WF_W-1:WF_W];
                m_desc = req_desc[2*DESC_W-1:DESC_W];
                m_g1   = m_g1 + 1;
            end else begin
                m_ack  = 2'b01;
                m_id   = req_wg_id[WG_W-1:0];
                m_nwf  = req_num_wf[WF_W-1:0];
                m_desc = req_desc[DESC_W-1:0];
                m_g0   = m_g0 + 1;
            end
        end
        if (wg_done && m_cnt == 0 && inc == 0) m_uf = 1'b1;
        else m_cnt = m_cnt + inc - (wg_done ? 1 : 0);
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (use_model) model_step();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [1:0] rv;
        logic       rcvd;
        logic       done;
        logic [1:0] ack;
        logic       valid;
        logic [1:0] cnt;
        logic       uf;
        logic [5:0] id;
    } vec_t;

    function automatic vec_t mk(logic r, logic [1:0] rv, logic rc, logic d,
                                logic [1:0] a, logic v, logic [1:0] c, logic u, logic [5:0] id);
        vec_t t;
        t.rst = r; t.rv = rv; t.rcvd = rc; t.done = d;
        t.ack = a; t.valid = v; t.cnt = c; t.uf = u; t.id = id;
        return t;
    endfunction

    localparam int NV = 25;
    vec_t tv [NV];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        //            rst rv    rc d  ack   v  cnt  uf id
        tv[0]  = mk(1, 2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 6'd0);
        // single requester 0, accept two cycles after the offer
        tv[1]  = mk(0, 2'b01, 0, 0, 2'b01, 1, 2'd0, 0, 6'd5);
        tv[2]  = mk(0, 2'b10, 0, 0, 2'b00, 1, 2'd0, 0, 6'd5);
        tv[3]  = mk(0, 2'b10, 0, 0, 2'b00, 1, 2'd0, 0, 6'd5);
        tv[4]  = mk(0, 2'b00, 1, 0, 2'b00, 0, 2'd1, 0, 6'd0);
        tv[5]  = mk(0, 2'b00, 1, 0, 2'b00, 0, 2'd1, 0, 6'd0);
        // drain, then completion with nothing in flight
        tv[6]  = mk(0, 2'b00, 0, 1, 2'b00, 0, 2'd0, 0, 6'd0);
        tv[7]  = mk(0, 2'b00, 0, 1, 2'b00, 0, 2'd0, 1, 6'd0);
        tv[8]  = mk(1, 2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 6'd0);
        // both requesting, immediate accept: 0,1,0,1 every three cycles
        tv[9]  = mk(0, 2'b11, 1, 0, 2'b01, 1, 2'd0, 0, 6'd5);
        tv[10] = mk(0, 2'b11, 1, 0, 2'b00, 0, 2'd1, 0, 6'd0);
        tv[11] = mk(0, 2'b11, 1, 0, 2'b00, 0, 2'd1, 0, 6'd0);
        tv[12] = mk(0, 2'b11, 1, 0, 2'b10, 1, 2'd1, 0, 6'd9);
        tv[13] = mk(0, 2'b11, 1, 1, 2'b00, 0, 2'd1, 0, 6'd0);
        tv[14] = mk(0, 2'b11, 1, 1, 2'b00, 0, 2'd0, 0, 6'd0);
        tv[15] = mk(0, 2'b11, 1, 0, 2'b01, 1, 2'd0, 0, 6'd5);
        tv[16] = mk(0, 2'b11, 1, 0, 2'b00, 0, 2'd1, 0, 6'd0);
        tv[17] = mk(0, 2'b11, 1, 0, 2'b00, 0, 2'd1, 0, 6'd0);
        tv[18] = mk(0, 2'b11, 1, 0, 2'b10, 1, 2'd1, 0, 6'd9);
        tv[19] = mk(0, 2'b11, 1, 0, 2'b00, 0, 2'd2, 0, 6'd0);
        tv[20] = mk(0, 2'b11, 1, 0, 2'b00, 0, 2'd2, 0, 6'd0);
        // saturated: nothing offered until a completion frees a slot
        tv[21] = mk(0, 2'b11, 1, 0, 2'b00, 0, 2'd2, 0, 6'd0);
        tv[22] = mk(0, 2'b11, 1, 1, 2'b00, 0, 2'd1, 0, 6'd0);
        tv[23] = mk(0, 2'b11, 1, 0, 2'b01, 1, 2'd1, 0, 6'd5);
        tv[24] = mk(1, 2'b00, 0, 0, 2'b00, 0, 2'd0, 0, 6'd0);

        req_wg_id  = {6'd9, 6'd5};
        req_num_wf = {4'd7, 4'd3};
        req_desc   = {64'hBBBB_0000_1111_2222, 64'hAAAA_3333_4444_5555};

        rst = 1'b1;
        tick();
        check("reset_payload_id", 64'(host_wg_id), 64'd0);
        check("reset_payload_desc", 64'(host_desc), 64'd0);

        for (int i = 0; i < NV; i++) begin
            rst       = tv[i].rst;
            req_valid = tv[i].rv;
            rcvd      = tv[i].rcvd;
            wg_done   = tv[i].done;
            tick();
            check($sformatf("vec%0d_ack", i), 64'(req_ack), 64'(tv[i].ack));
            check($sformatf("vec%0d_valid", i), 64'(host_wg_valid), 64'(tv[i].valid));
            check($sformatf("vec%0d_count", i), 64'(inflight_count), 64'(tv[i].cnt));
            check($sformatf("vec%0d_underflow", i), 64'(underflow_err), 64'(tv[i].uf));
            if (tv[i].valid) begin
                check($sformatf("vec%0d_id", i), 64'(host_wg_id), 64'(tv[i].id));
                check($sformatf("vec%0d_nwf", i), 64'(host_num_wf),
                      tv[i].id == 6'd5 ? 64'd3 : 64'd7);
            end
        end

        // Async reset mid-offer, then tie must go to requester 0 again
        rst = 1'b0; req_valid = 2'b10; rcvd = 1'b0; wg_done = 1'b0;
        tick();
        check("rst_seq_grant1", 64'(req_ack), 64'b10);
        req_valid = 2'b00; rcvd = 1'b1;
        tick();
        check("rst_seq_count1", 64'(inflight_count), 64'd1);
        rcvd = 1'b0;
        tick();
        req_valid = 2'b01;
        tick();
        check("rst_seq_grant0", 64'(req_ack), 64'b01);
        check("rst_seq_offer", 64'(host_wg_valid), 64'd1);
        req_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(host_wg_valid), 64'd0);
        check("rst_async_count", 64'(inflight_count), 64'd0);
        check("rst_async_id", 64'(host_wg_id), 64'd0);
        check("rst_async_ack", 64'(req_ack), 64'd0);
        tick();
        rst = 1'b0; req_valid = 2'b11;
        tick();
        check("rst_after_tie_grant0", 64'(req_ack), 64'b01);
        check("rst_after_count", 64'(inflight_count), 64'd0);
        req_valid = 2'b00;

        // Randomized run against the reference model
        rst = 1'b1;
        model_reset();
        use_model = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            req_valid  = 2'($urandom);
            req_wg_id  = 12'($urandom);
            req_num_wf = 8'($urandom);
            req_desc   = {$urandom, $urandom, $urandom, $urandom};
            rcvd       = ($urandom_range(0, 1) == 0);
            wg_done    = ($urandom_range(0, 5) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            tick();
            check("rnd_ack", 64'(req_ack), 64'(m_ack));
            check("rnd_valid", 64'(host_wg_valid), 64'(m_offer));
            check("rnd_count", 64'(inflight_count), 64'(m_cnt));
            check("rnd_underflow", 64'(underflow_err), 64'(m_uf));
            if (m_offer) begin
                check("rnd_id", 64'(host_wg_id), 64'(m_id));
                check("rnd_nwf", 64'(host_num_wf), 64'(m_nwf));
                check("rnd_desc", 64'(host_desc), m_desc);
            end
`ifdef WG_HOST_ARBITER_STATS_EN
            check("rnd_grant_cnt0", 64'(grant_cnt0), 64'(16'(m_g0)));
            check("rnd_grant_cnt1", 64'(grant_cnt1), 64'(16'(m_g1)));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
